// File: rtl/in_port_arbiter.sv
// in_port_arbiter: shares the CPU's single in_port/ready_in handshake among
// N_REQ producers. Grants one requester, latches its byte onto in_port, plays
// a setup / ready_in-high / gap strobe sequence, then pulses ack for one cycle.
// Optional build macro: IN_ARB_FIXED_PRIO_EN selects lowest-index-wins
// arbitration instead of round-robin (and removes the round-robin pointer).
module in_port_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUS_WIDTH    = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*BUS_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]           ack,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic [BUS_WIDTH-1:0]       in_port,
  output logic                       ready_in
);

  localparam int IDW     = $clog2(N_REQ);
  localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_ALL = (MAX_SH > GAP_CYCLES) ? MAX_SH : GAP_CYCLES;
  localparam int CNT_MAX = MAX_ALL - 1;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] in_port_q, in_port_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 ready_in_q, ready_in_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic [IDW-1:0]       winner;

`ifdef IN_ARB_FIXED_PRIO_EN

  // Winner selection: lowest-index asserted request always wins.
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
  end

`else

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  // Winner selection: first asserted request searching upward from rr_ptr,
  // wrapping past N_REQ-1 back to 0.
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int             sum;
      logic [IDW-1:0] idx;
      sum = int'(rr_ptr_q) + i;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = IDW'(sum);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Pointer advance: the search after a grant starts just past the winner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && found) begin
      rr_ptr_d = (winner == IDW'(N_REQ - 1)) ? '0 : winner + IDW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

`endif

  // Next-state and registered-output logic for the handshake sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_port_d = in_port_q;
    grant_d   = grant_q;
    ack_d     = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          in_port_d = req_data[int'(winner)*BUS_WIDTH +: BUS_WIDTH];
          grant_d   = winner;
          cnt_d     = CW'(SETUP_CYCLES - 1);
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(HOLD_CYCLES - 1);
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          cnt_d          = CW'(GAP_CYCLES - 1);
          ack_d[grant_q] = 1'b1;
          state_d        = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Strobe and busy are registered from the next state, so they change on
    // the same edge as the state and never follow req combinationally.
    ready_in_d = (state_d == STROBE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transfer without an ack.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_port_q  <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      ready_in_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_port_q  <= in_port_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      ready_in_q <= ready_in_d;
      busy_q     <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign in_port  = in_port_q;
  assign ready_in = ready_in_q;

endmodule

// File: tb/tb_in_port_arbiter.sv
// Directed testbench for in_port_arbiter (default parameters). Expected
// grant order switches when built with IN_ARB_FIXED_PRIO_EN.
module tb_in_port_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  in_port;
  logic        ready_in;

  int errors = 0;
  int checks = 0;

  in_port_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .in_port  (in_port),
    .ready_in (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic [7:0] exp_port);
    check({tag, "_in_port"}, 32'(in_port), 32'(exp_port));
    check({tag, "_ready"},   32'(ready_in), 32'd0);
    check({tag, "_busy"},    32'(busy), 32'd0);
    check({tag, "_ack"},     32'(ack), 32'd0);
  endtask

  // One full transfer starting at the next edge (E0 = k 0). The served
  // requester drops req on seeing ack and optionally re-asserts a cycle later.
  task automatic xfer(input string tag, input int id, input logic [7:0] data,
                      input bit reassert, input bit poke);
    logic [3:0] exp_ack;
    for (int k = 0; k <= 8; k++) begin
      step();
      exp_ack = (k == 6) ? (4'b0001 << id) : 4'b0000;
      if (k == 0) check({tag, "_grant"}, 32'(grant_id), 32'(id));
      check($sformatf("%s_port_k%0d", tag, k),  32'(in_port), 32'(data));
      check($sformatf("%s_ready_k%0d", tag, k), 32'(ready_in), 32'((k >= 2 && k <= 5) ? 1 : 0));
      check($sformatf("%s_ack_k%0d", tag, k),   32'(ack), 32'(exp_ack));
      check($sformatf("%s_busy_k%0d", tag, k),  32'(busy), 32'((k < 8) ? 1 : 0));
      if (poke && k == 3) req_data[15:8] = 8'h3C;
      if (k == 6) req[id] = 1'b0;
      if (k == 7 && reassert) req[id] = 1'b1;
    end
  endtask

  int exp_order [5];

  initial begin
`ifdef IN_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    reset    = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0;

    // Reset held for three cycles, then twenty idle cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet($sformatf("rst%0d", i), 8'h00);
      check("rst_grant", 32'(grant_id), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_quiet($sformatf("idle%0d", i), 8'h00);
    end

    // All four requesting: order depends on the arbitration mode.
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req      = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      xfer($sformatf("rr%0d", t), exp_order[t],
           8'h10 + 8'(exp_order[t]), 1'b1, 1'b0);
    end
    req = 4'b0000;

    // Single transfer from requester 1; its data changes during the strobe.
    req_data[15:8] = 8'hA5;
    req            = 4'b0010;
    xfer("single", 1, 8'hA5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_quiet($sformatf("hold%0d", i), 8'hA5);
    end

    // Reset while ready_in is high: everything clears at once, no ack.
    req = 4'b0100;
    for (int k = 0; k <= 3; k++) begin
      step();
      if (k == 0) check("abort_grant", 32'(grant_id), 32'd2);
    end
    check("abort_strobe_high", 32'(ready_in), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_ready_async", 32'(ready_in), 32'd0);
    check("abort_port_async",  32'(in_port), 32'd0);
    check("abort_busy_async",  32'(busy), 32'd0);
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      check_quiet($sformatf("abort%0d", i), 8'h00);
    end
    reset = 1'b0;
    step();
    check_quiet("post_rst", 8'h00);

    // After reset the pointer is back at 0; requester 3 is served normally.
    req_data[31:24] = 8'h5E;
    req             = 4'b1000;
    xfer("after_rst", 3, 8'h5E, 1'b0, 1'b0);
    step();
    check_quiet("final", 8'h5E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/in_port_arbiter.md
# in_port_arbiter

- Shares the CPU's single `in_port`/`ready_in` input handshake between up to `N_REQ` producers.
- Grants one requester at a time, latches its byte and drives `in_port`. It then generates the clean low→high→low `ready_in` strobe that the CPU's rising-edge pattern detector and ready-wait instructions consume, and returns a one-cycle `ack`.
- Sits between the external input sources and the CPU top level.

## Interface

Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `BUS_WIDTH`, 8, data width; must match CPU `BUS_WIDTH`
- `SETUP_CYCLES`, 2, cycles `in_port` is stable with `ready_in` low before the strobe (≥1)
- `HOLD_CYCLES`, 4, cycles `ready_in` is held high (≥2)
- `GAP_CYCLES`, 2, cycles `ready_in` is held low after the strobe, before the next grant (≥1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  N_REQ  per-requester transfer request; level, held until `ack`
- `req_data`  in  N_REQ×BUS_WIDTH  per-requester byte
- `ack`  out  N_REQ  one-cycle pulse to the served requester
- `grant_id`  out  $clog2(N_REQ)  index of the current/last granted requester
- `busy`  out  1  high in any state other than IDLE
- `in_port`  out  BUS_WIDTH  to CPU `in_port`
- `ready_in`  out  1  to CPU `ready_in`

## Operation

- FSM states: IDLE, SETUP, STROBE, GAP. One down-counter `cnt`, sized for max(SETUP, HOLD, GAP).
- IDLE:
  - If any `req` bit is set, pick the winner by round-robin, starting the search at `rr_ptr`.
  - At that edge: latch `req_data[winner]` into the `in_port` register, set `grant_id` = winner, set `rr_ptr` = winner+1 mod N_REQ, load `cnt` = SETUP_CYCLES-1, and go to SETUP.
- SETUP: `ready_in`=0. When `cnt`==0, load HOLD_CYCLES-1 and go to STROBE.
- STROBE: `ready_in`=1. When `cnt`==0, load GAP_CYCLES-1, pulse `ack[grant_id]` for the next cycle, and go to GAP.
- GAP: `ready_in`=0. When `cnt`==0, go to IDLE.
- `in_port` holds the latched byte from the grant until the next grant. Changes on `req_data` after the grant are ignored.
- `req` is sampled only in IDLE. A `req` that drops before being sampled is never served. A `req` still high in the IDLE cycle after its `ack` is treated as a new request.
- `ack` is registered, so exactly one bit is high for exactly one cycle per transfer.
- Reset (asynchronous, any state, including mid-strobe):
  - State IDLE, `cnt`=0, `rr_ptr`=0.
  - Outputs: `in_port`=0, `ready_in`=0, `ack`=0, `grant_id`=0, `busy`=0.
  - The aborted transfer is not acked.

## Timing

- All outputs are registered; none depends combinationally on inputs.
- Sequence for a `req` first sampled at edge E0 (state IDLE):
  - `busy`=1, `grant_id` and `in_port` valid from E0.
  - `ready_in` rises at E0+SETUP_CYCLES.
  - `ready_in` falls at E0+SETUP_CYCLES+HOLD_CYCLES; `ack` is high for that one cycle.
  - State returns to IDLE at E0+SETUP+HOLD+GAP.
- Next grant is at the following edge at the earliest. Throughput is one transfer per SETUP+HOLD+GAP+1 cycles (9 with defaults).
- Simultaneous requests: exactly one grant per IDLE sample.
- `rr_ptr` wraps from N_REQ-1 to 0.
- Each requester waits at most N_REQ-1 transfers.

## Configuration

- `IN_ARB_FIXED_PRIO_EN` defined:
  - The lowest-index asserted `req` always wins.
  - `rr_ptr` is not implemented.
- Not defined: round-robin arbitration as described under Operation.

## Test plan

- Reset then idle: hold `reset`=1 for 3 cycles, then `req`=0 for 20 cycles → `in_port`=0x00, `ready_in`=0, `busy`=0, `ack`=0 throughout.
- Single transfer: `req`=0b0010, `req_data[1]`=0xA5 → `grant_id`=1 and `in_port`=0xA5 from E0; `ready_in` high on cycles E0+2..E0+5; `ack`=0b0010 for one cycle at E0+6; IDLE at E0+8.
- Round-robin fairness: `req`=0b1111 held, re-asserted after each `ack` → grant order 0,1,2,3,0, with each transfer spaced 9 cycles.
- Fixed priority (`IN_ARB_FIXED_PRIO_EN` defined): same stimulus → grant order 0,0,0.
- Data stability: change `req_data[1]` from 0xA5 to 0x3C during STROBE → `in_port` stays 0xA5 until the next grant.
- Reset mid-strobe: assert `reset` while `ready_in`=1 → `ready_in`=0 and `in_port`=0 immediately (asynchronous), no `ack`; after release with `req`=0b1000 → `grant_id`=3, served with the normal timing.
